// File: rtl/xgmii_axis_pkg.sv
// Shared types and constants for the XGMII TX AXI4-Stream path.
package xgmii_axis_pkg;

   localparam int XGMII_DATA_WIDTH = 64;
   localparam int XGMII_KEEP_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      GAP  = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic [XGMII_DATA_WIDTH-1:0] dat;
      logic [XGMII_KEEP_WIDTH-1:0] keep;
      logic                        last;
   } axis_beat_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin picker: one-hot winner is the first requester after 'last', wrapping upward.
// Purely combinational, no backpressure; winner is zero when nothing requests.
module rr_priority_pick #(
   parameter int N  = 2,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  request,
   input  logic [IW-1:0] last,
   output logic [N-1:0]  winner
);

   always_comb begin
      logic          found;
      logic [IW-1:0] idx;
      winner = '0;
      found  = 1'b0;
      idx    = '0;
      for (int k = 1; k <= N; k++) begin
         idx = IW'((int'(last) + k) % N);
         if (!found && request[idx]) begin
            winner[idx] = 1'b1;
            found       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/xgmii_tx_frame_arbiter.sv
// Round-robin frame arbiter onto one TX stream: grant 1 cycle after request, zero-latency datapath.
// m_axis_tready passes straight to the granted source only; IFG_CYCLES idle cycles follow each frame.
module xgmii_tx_frame_arbiter
   import xgmii_axis_pkg::*;
#(
   parameter int NUM_PORTS  = 2,
   parameter int DATA_WIDTH = 64,
   parameter int IFG_CYCLES = 1,
   parameter int MAX_BEATS  = 1200
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [NUM_PORTS-1:0]              s_axis_tvalid,
   output logic [NUM_PORTS-1:0]              s_axis_tready,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] s_axis_tkeep,
   input  logic [NUM_PORTS-1:0]              s_axis_tlast,
   output logic                              m_axis_tvalid,
   input  logic                              m_axis_tready,
   output logic [DATA_WIDTH-1:0]             m_axis_tdata,
   output logic [DATA_WIDTH/8-1:0]           m_axis_tkeep,
   output logic                              m_axis_tlast,
   output logic [NUM_PORTS-1:0]              grant,
   output logic                              frame_done,
   output logic                              error_oversize
);

   localparam int IW = $clog2(NUM_PORTS);
   localparam int KW = DATA_WIDTH / 8;

   if (DATA_WIDTH != XGMII_DATA_WIDTH) begin : g_bad_width
      $error("xgmii_tx_frame_arbiter: DATA_WIDTH must be 64");
   end
   if (NUM_PORTS < 2 || NUM_PORTS > 4) begin : g_bad_ports
      $error("xgmii_tx_frame_arbiter: NUM_PORTS must be 2..4");
   end
   if (IFG_CYCLES < 0 || IFG_CYCLES > 15 || MAX_BEATS < 8 || MAX_BEATS > 4095) begin : g_bad_cfg
      $error("xgmii_tx_frame_arbiter: IFG_CYCLES or MAX_BEATS out of range");
   end

   arb_state_t           state, state_nxt;
   logic [NUM_PORTS-1:0] grant_nxt, pick;
   logic [IW-1:0]        last_idx, last_nxt, pick_idx;
   logic [3:0]           ifg_cnt, ifg_nxt;
   logic [11:0]          beat_cnt, beat_nxt;
   logic                 ovs_seen, ovs_nxt;
   axis_beat_t           src [NUM_PORTS];
   axis_beat_t           sel;
   logic                 xfer, beat_hs;

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_src
      assign src[i] = '{dat:  s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH],
                        keep: s_axis_tkeep[i*KW +: KW],
                        last: s_axis_tlast[i]};
   end

   rr_priority_pick #(.N(NUM_PORTS), .IW(IW)) u_pick (
      .request (s_axis_tvalid),
      .last    (last_idx),
      .winner  (pick)
   );

   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (pick[i]) pick_idx = IW'(i);
      end
   end

   // last_idx doubles as the current owner while in XFER
   assign xfer           = (state == XFER);
   assign sel            = src[last_idx];
   assign m_axis_tvalid  = xfer & s_axis_tvalid[last_idx];
   assign m_axis_tdata   = xfer ? sel.dat  : '0;
   assign m_axis_tkeep   = xfer ? sel.keep : '0;
   assign m_axis_tlast   = xfer & sel.last;
   assign s_axis_tready  = xfer ? (grant & {NUM_PORTS{m_axis_tready}}) : '0;
   assign beat_hs        = m_axis_tvalid & m_axis_tready;
   assign frame_done     = beat_hs & m_axis_tlast;
   assign error_oversize = beat_hs & ~ovs_seen & (beat_cnt == 12'(MAX_BEATS));

   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      last_nxt  = last_idx;
      ifg_nxt   = ifg_cnt;
      beat_nxt  = beat_cnt;
      ovs_nxt   = ovs_seen;
      case (state)
         IDLE: begin
            if (|s_axis_tvalid) begin
               state_nxt = XFER;
               grant_nxt = pick;
               last_nxt  = pick_idx;
               beat_nxt  = '0;
               ovs_nxt   = 1'b0;
            end
         end
         XFER: begin
            if (beat_hs) begin
               if (beat_cnt != 12'hFFF) beat_nxt = beat_cnt + 12'd1;
               if (error_oversize) ovs_nxt = 1'b1;
               if (m_axis_tlast) begin
                  grant_nxt = '0;
                  if (IFG_CYCLES > 0) begin
                     state_nxt = GAP;
                     ifg_nxt   = 4'(IFG_CYCLES);
                  end else begin
                     state_nxt = IDLE;
                  end
               end
            end
         end
         GAP: begin
            if (ifg_cnt <= 4'd1) begin
               state_nxt = IDLE;
               ifg_nxt   = '0;
            end else begin
               ifg_nxt = ifg_cnt - 4'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         grant    <= '0;
         last_idx <= IW'(NUM_PORTS - 1);
         ifg_cnt  <= '0;
         beat_cnt <= '0;
         ovs_seen <= 1'b0;
      end else begin
         state    <= state_nxt;
         grant    <= grant_nxt;
         last_idx <= last_nxt;
         ifg_cnt  <= ifg_nxt;
         beat_cnt <= beat_nxt;
         ovs_seen <= ovs_nxt;
      end
   end

endmodule

// File: tb/tb_xgmii_tx_frame_arbiter.sv
// Scoreboard bench: frame stimulus pushes expected beats, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_xgmii_tx_frame_arbiter;
   import xgmii_axis_pkg::*;

   localparam int NP  = 2;
   localparam int MXB = 8;

   typedef struct {
      logic [63:0] dat;
      logic [7:0]  keep;
      logic        last;
      int          port;
      logic        ovs;
   } exp_t;

   logic            clk, rst_n;
   logic [NP-1:0]   s_axis_tvalid, s_axis_tready, s_axis_tlast;
   logic [NP*64-1:0] s_axis_tdata;
   logic [NP*8-1:0] s_axis_tkeep;
   logic            m_axis_tvalid, m_axis_tready, m_axis_tlast;
   logic [63:0]     m_axis_tdata;
   logic [7:0]      m_axis_tkeep;
   logic [NP-1:0]   grant;
   logic            frame_done, error_oversize;

   int         n_cmp = 0, n_err = 0;
   int         cyc = 0, fr_n = 0, ovs_pulses = 0;
   int         st_cyc [32];
   int         dn_cyc [32];
   logic [NP-1:0] fr_gnt [32];
   logic       in_frame;
   logic       drv_hs [NP];
   exp_t       exp_q [$];
   axis_beat_t src_q [NP][$];

   xgmii_tx_frame_arbiter #(
      .NUM_PORTS(NP), .DATA_WIDTH(64), .IFG_CYCLES(1), .MAX_BEATS(MXB)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
      .grant(grant), .frame_done(frame_done), .error_oversize(error_oversize)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_frame(input int p, input int n, input logic [63:0] base);
      for (int i = 0; i < n; i++) begin
         axis_beat_t b;
         exp_t       e;
         b.dat  = base + 64'(i);
         b.keep = (i == n - 1) ? 8'h0F : 8'hFF;
         b.last = (i == n - 1);
         src_q[p].push_back(b);
         e.dat  = b.dat;
         e.keep = b.keep;
         e.last = b.last;
         e.port = p;
         e.ovs  = (i + 1 == MXB + 1);
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_frames(input int n, input string name);
      int k = 0;
      while (fr_n < n && k < 300) begin
         @(negedge clk); #2;
         k++;
      end
      n_cmp++;
      if (fr_n < n) begin
         n_err++;
         $display("FAIL %s: timeout, frames seen %0d, required %0d", name, fr_n, n);
      end
   endtask

   task automatic wait_tvalid(input int p, input string name);
      int k = 0;
      do begin
         @(negedge clk); #2;
         k++;
      end while (!s_axis_tvalid[p] && k < 50);
      chk(name, 64'(s_axis_tvalid[p]), 64'd1);
   endtask

   task automatic wait_grant(input logic [NP-1:0] g, input string name);
      int k = 0;
      do begin
         @(negedge clk); #2;
         k++;
      end while (grant !== g && k < 50);
      chk(name, 64'(grant), 64'(g));
   endtask

   // source driver: updates just after posedge, consumes beats handshaken at the prior negedge
   initial begin
      s_axis_tvalid = '0;
      s_axis_tdata  = '0;
      s_axis_tkeep  = '0;
      s_axis_tlast  = '0;
      forever begin
         @(negedge clk);
         for (int p = 0; p < NP; p++) drv_hs[p] = s_axis_tvalid[p] & s_axis_tready[p];
         @(posedge clk); #1;
         for (int p = 0; p < NP; p++) begin
            if (drv_hs[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
            if (src_q[p].size() > 0) begin
               s_axis_tvalid[p]          = 1'b1;
               s_axis_tdata[p*64 +: 64]  = src_q[p][0].dat;
               s_axis_tkeep[p*8 +: 8]    = src_q[p][0].keep;
               s_axis_tlast[p]           = src_q[p][0].last;
            end else begin
               s_axis_tvalid[p] = 1'b0;
               s_axis_tlast[p]  = 1'b0;
            end
         end
      end
   end

   // monitor
   initial begin
      exp_t e;
      in_frame = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            in_frame = 1'b0;
         end else begin
            if (error_oversize) ovs_pulses++;
            if (m_axis_tvalid)
               chk("s_tready_follow", 64'(s_axis_tready), 64'(m_axis_tready ? grant : '0));
            if (m_axis_tvalid && m_axis_tready) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected_beat: got data %0h, expected no beat", m_axis_tdata);
               end else begin
                  e = exp_q.pop_front();
                  chk("m_tdata", m_axis_tdata, e.dat);
                  chk("m_tkeep", 64'(m_axis_tkeep), 64'(e.keep));
                  chk("m_tlast", 64'(m_axis_tlast), 64'(e.last));
                  chk("beat_grant", 64'(grant), 64'(NP'(1) << e.port));
                  chk("frame_done", 64'(frame_done), 64'(e.last));
                  chk("error_oversize", 64'(error_oversize), 64'(e.ovs));
               end
               if (!in_frame && fr_n < 32) begin
                  st_cyc[fr_n] = cyc;
                  fr_gnt[fr_n] = grant;
                  in_frame     = 1'b1;
               end
               if (m_axis_tlast && fr_n < 32) begin
                  dn_cyc[fr_n] = cyc;
                  fr_n++;
                  in_frame = 1'b0;
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, frames seen %0d", fr_n);
      $fatal(1, "watchdog");
   end

   initial begin
      int ovs_before;
      rst_n         = 1'b0;
      m_axis_tready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_grant", 64'(grant), 64'd0);
      chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("rst_s_tready", 64'(s_axis_tready), 64'd0);
      chk("rst_frame_done", 64'(frame_done), 64'd0);
      chk("rst_oversize", 64'(error_oversize), 64'd0);
      @(posedge clk); #1 rst_n = 1'b1;

      // port0 3-beat frame, grant one cycle after tvalid, then a gap cycle
      @(negedge clk);
      push_frame(0, 3, 64'h1000);
      wait_tvalid(0, "t1_tvalid_seen");
      chk("t1_grant_before", 64'(grant), 64'd0);
      @(negedge clk); #2;
      chk("t1_grant_latency", 64'(grant), 64'd1);
      chk("t1_m_tvalid", 64'(m_axis_tvalid), 64'd1);
      wait_frames(1, "t1_frames");
      @(negedge clk); #2;
      chk("t1_gap_grant", 64'(grant), 64'd0);
      chk("t1_gap_m_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("t1_frame_len", 64'(dn_cyc[0] - st_cyc[0]), 64'd2);
      chk("t1_frame_grant", 64'(fr_gnt[0]), 64'd1);
      repeat (3) @(negedge clk);

      // port1 requests mid-frame of port0: no preemption
      push_frame(0, 4, 64'h2000);
      wait_grant(2'b01, "t4_grant_p0");
      push_frame(1, 2, 64'h3000);
      wait_frames(3, "t4_frames");
      chk("t4_first_grant", 64'(fr_gnt[1]), 64'd1);
      chk("t4_second_grant", 64'(fr_gnt[2]), 64'd2);
      chk("t4_gap_to_p1", 64'(st_cyc[2] - dn_cyc[1]), 64'd3);
      repeat (3) @(negedge clk);

      // both ports continuously requesting: alternating grants with 1 gap cycle
      push_frame(0, 2, 64'h4000);
      push_frame(1, 2, 64'h4100);
      push_frame(0, 2, 64'h4200);
      push_frame(1, 2, 64'h4300);
      wait_frames(7, "t2_frames");
      chk("t2_grant_0", 64'(fr_gnt[3]), 64'd1);
      chk("t2_grant_1", 64'(fr_gnt[4]), 64'd2);
      chk("t2_grant_2", 64'(fr_gnt[5]), 64'd1);
      chk("t2_grant_3", 64'(fr_gnt[6]), 64'd2);
      for (int k = 4; k <= 6; k++) chk("t2_ifg", 64'(st_cyc[k] - dn_cyc[k-1]), 64'd3);
      repeat (3) @(negedge clk);

      // m_axis_tready toggling during a 4-beat frame
      push_frame(0, 4, 64'h5000);
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         m_axis_tready = i[0];
      end
      @(posedge clk); #1 m_axis_tready = 1'b1;
      wait_frames(8, "t3_frames");
      chk("t3_all_beats_seen", 64'(exp_q.size()), 64'd0);
      repeat (3) @(negedge clk);

      // oversize: 10-beat frame with MAX_BEATS=8 -> one pulse on beat 9
      ovs_before = ovs_pulses;
      push_frame(0, 10, 64'h6000);
      wait_frames(9, "t5_frames");
      chk("t5_oversize_pulses", 64'(ovs_pulses - ovs_before), 64'd1);
      chk("t5_frame_len", 64'(dn_cyc[8] - st_cyc[8]), 64'd9);
      repeat (3) @(negedge clk);

      // reset asserted on beat 2
      push_frame(0, 4, 64'h7000);
      wait_grant(2'b01, "t6_grant_p0");
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("t6_rst_grant", 64'(grant), 64'd0);
      chk("t6_rst_s_tready", 64'(s_axis_tready), 64'd0);
      exp_q.delete();
      src_q[0].delete();
      repeat (2) @(negedge clk);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      push_frame(0, 2, 64'h8000);
      wait_tvalid(0, "t6_tvalid_seen");
      chk("t6_grant_before", 64'(grant), 64'd0);
      @(negedge clk); #2;
      chk("t6_grant_latency", 64'(grant), 64'd1);
      wait_frames(10, "t6_frames");
      chk("t6_frame_grant", 64'(fr_gnt[9]), 64'd1);
      chk("t6_queue_empty", 64'(exp_q.size()), 64'd0);
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/xgmii_tx_frame_arbiter.md
XGMII_TX_FRAME_ARBITER -- requirements
Module: xgmii_tx_frame_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of AXI4-Stream TX sources (legal 2..4).
REQ-002 SHALL have parameter DATA_WIDTH, default 64, beat width (only 64 legal; elaboration error otherwise).
REQ-003 SHALL have parameter IFG_CYCLES, default 1, idle cycles forced after each frame (legal 0..15).
REQ-004 SHALL have parameter MAX_BEATS, default 1200, beats per frame before the oversize flag (legal 8..4095).
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port clk, input, 1 bit: sole clock.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port s_axis_tvalid, input, NUM_PORTS bits: per-source valid.
REQ-009 SHALL have port s_axis_tready, output, NUM_PORTS bits: per-source ready.
REQ-010 SHALL have port s_axis_tdata, input, NUM_PORTS*64 bits: source i at bits [64i+63:64i].
REQ-011 SHALL have port s_axis_tkeep, input, NUM_PORTS*8 bits: packed as tdata.
REQ-012 SHALL have port s_axis_tlast, input, NUM_PORTS bits: per-source end of frame.
REQ-013 SHALL have ports m_axis_tvalid/tready/tdata/tkeep/tlast, out/in/out/out/out, 1/1/64/8/1 bits: toward TX bridge.
REQ-014 SHALL have port grant, output, NUM_PORTS bits: one-hot owner, zero when idle.
REQ-015 SHALL have port frame_done, output, 1 bit: one-cycle pulse on the tlast handshake.
REQ-016 SHALL have port error_oversize, output, 1 bit: one-cycle pulse when a frame reaches beat MAX_BEATS+1.

Function
REQ-017 SHALL implement the states IDLE, XFER and GAP.
REQ-018 IDLE: SHALL drive all s_axis_tready=0, m_axis_tvalid=0 and grant=0; when any s_axis_tvalid=1, SHALL latch the winner into grant and enter XFER next cycle (1-cycle arbitration latency).
REQ-019 Winner SHALL be chosen round-robin: the first requesting port after the last granted port, in increasing index with wrap; after reset the last granted port is NUM_PORTS-1, so port 0 has first priority.
REQ-020 XFER: m_axis_tvalid/tdata/tkeep/tlast SHALL combinationally equal the granted source's signals, and s_axis_tready[g] SHALL equal m_axis_tready; all other s_axis_tready bits SHALL be 0 (zero datapath latency).
REQ-021 Grant SHALL be held until the tlast handshake (m_axis_tvalid & m_axis_tready & m_axis_tlast); requests arriving mid-frame SHALL NOT preempt it.
REQ-022 On the tlast handshake, SHALL pulse frame_done and enter GAP if IFG_CYCLES>0, else IDLE.
REQ-023 GAP: SHALL behave as IDLE outputs for exactly IFG_CYCLES cycles (4-bit down-counter), then enter IDLE; requests during GAP SHALL be held off, not dropped.
REQ-024 SHALL count accepted beats per frame in a 12-bit counter (reset at frame start); error_oversize SHALL pulse once per frame when beat MAX_BEATS+1 is accepted, and the frame SHALL continue unmodified.
REQ-025 A single-beat frame (tlast on first beat) SHALL be legal and count as one beat.
REQ-026 A source dropping tvalid mid-frame SHALL keep the grant; the arbiter SHALL wait indefinitely.

Reset
REQ-027 On rst_n=0: state=IDLE, grant=0, m_axis_tvalid=0, all s_axis_tready=0, frame_done=0, error_oversize=0, counters=0, last-granted=NUM_PORTS-1, asynchronously.
REQ-028 Reset mid-frame SHALL abandon the frame; the first post-reset frame SHALL be arbitrated fresh.

Structure
REQ-029 The state enum and the constants XGMII_DATA_WIDTH=64 and XGMII_KEEP_WIDTH=8 SHALL live in shared package xgmii_axis_pkg.
REQ-030 The round-robin picker SHALL be the combinational sub-module rr_priority_pick (inputs: request, last; output: one-hot winner).

Verification
REQ-031 SHALL cover: reset release, port0 sends a 3-beat frame with tready=1 -> grant=01 one cycle after tvalid, 3 beats on m_axis, frame_done on beat 3, then 1 GAP cycle.
REQ-032 SHALL cover: both ports request continuously, 2-beat frames -> grant order 01,10,01,10 with an IFG of 1 cycle between frames.
REQ-033 SHALL cover: m_axis_tready toggling 1/0 during a 4-beat frame -> the source sees the identical tready pattern, no beat lost or duplicated, data matches.
REQ-034 SHALL cover: port1 requests mid-frame of port0 -> no preemption; port1 is granted only after port0's tlast plus the GAP.
REQ-035 SHALL cover: MAX_BEATS=8, 10-beat frame -> error_oversize pulses exactly once, on beat 9; all 10 beats are forwarded.
REQ-036 SHALL cover: rst_n asserted on beat 2 -> m_axis_tvalid=0 and grant=0 immediately; after release, a new port0 request is granted cleanly.
